// File: rtl/cv32e40p_apu_dispatcher.sv
// Routes one core APU port to NUM_UNITS units; tag FIFO + per-unit result buffers restore issue order.
// Grant is combinational; a result reaches the core one cycle after capture; back-pressure is the grant held while DEPTH ops are outstanding.

module cv32e40p_apu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_push,
    input  logic [W-1:0]           i_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_dat,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    // Storage is not reset; pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    assign o_dat   = r_mem[r_rptr];
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
endmodule

module cv32e40p_apu_dispatcher #(
    parameter int  NUM_UNITS = 2,
    parameter int  DEPTH     = 4,
    parameter int  NARGS     = 3,
    parameter int  WOP       = 6,
    parameter int  NDSFLAGS  = 15,
    parameter int  NUSFLAGS  = 5,
    localparam int SEL_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            apu_req_i,
    output logic                            apu_gnt_o,
    input  logic [SEL_W-1:0]                apu_unit_i,
    input  logic [NARGS*32-1:0]             apu_operands_i,
    input  logic [WOP-1:0]                  apu_op_i,
    input  logic [NDSFLAGS-1:0]             apu_flags_i,
    output logic                            apu_rvalid_o,
    output logic [31:0]                     apu_rdata_o,
    output logic [NUSFLAGS-1:0]             apu_rflags_o,
    output logic [NUM_UNITS-1:0]            unit_req_o,
    input  logic [NUM_UNITS-1:0]            unit_gnt_i,
    output logic [NARGS*32-1:0]             unit_operands_o,
    output logic [WOP-1:0]                  unit_op_o,
    output logic [NDSFLAGS-1:0]             unit_flags_o,
    input  logic [NUM_UNITS-1:0]            unit_rvalid_i,
    input  logic [NUM_UNITS*32-1:0]         unit_rdata_i,
    input  logic [NUM_UNITS*NUSFLAGS-1:0]   unit_rflags_i,
    output logic                            busy_o,
    output logic                            err_o
);
    localparam int             CW = $clog2(DEPTH) + 1;
    localparam int             RW = 32 + NUSFLAGS;
    localparam int             TW = SEL_W + 1;
    localparam logic [SEL_W:0] NU = (SEL_W + 1)'(NUM_UNITS);

    logic                 w_sel_vld;
    logic                 w_full;
    logic                 w_req;
    logic                 w_unit_gnt;
    logic                 w_pop;
    logic                 w_head_rdy;
    logic                 w_tag_empty;
    logic [TW-1:0]        w_tag_in;
    logic [TW-1:0]        w_tag_head;
    logic [CW-1:0]        w_cnt;
    logic [RW-1:0]        w_head_dat;
    logic [NUM_UNITS-1:0] w_unit_req;
    logic [NUM_UNITS-1:0] w_head_sel;
    logic [NUM_UNITS-1:0] w_buf_pop;
    logic [NUM_UNITS-1:0] w_buf_empty;
    logic [NUM_UNITS-1:0] w_cap;
    logic [RW-1:0]        w_buf_dat [NUM_UNITS];
    logic [CW-1:0]        w_buf_cnt [NUM_UNITS];
    logic [CW-1:0]        r_out     [NUM_UNITS];
    logic                 r_err;

    assign w_sel_vld = ({1'b0, apu_unit_i} < NU);
    assign w_full    = (w_cnt == CW'(DEPTH));
    assign w_req     = apu_req_i & ~w_full;

    always_comb begin
        w_unit_req = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_unit_req[k] = w_req & w_sel_vld & (apu_unit_i == SEL_W'(k));
        end
    end

    assign w_unit_gnt = |(w_unit_req & unit_gnt_i);
    // Out-of-range selects are accepted locally and answered with a zero result.
    assign apu_gnt_o  = w_sel_vld ? w_unit_gnt : w_req;
    assign unit_req_o = w_unit_req;
    assign w_tag_in   = {~w_sel_vld, apu_unit_i};

    cv32e40p_apu_fifo #(.W(TW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (apu_gnt_o),
        .i_dat   (w_tag_in),
        .i_pop   (w_pop),
        .o_dat   (w_tag_head),
        .o_empty (w_tag_empty),
        .o_cnt   (w_cnt)
    );

    always_comb begin
        w_cap = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_cap[k] = unit_rvalid_i[k] & (r_out[k] > w_buf_cnt[k]);
        end
    end

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_buf
        cv32e40p_apu_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .i_push  (w_cap[k]),
            .i_dat   ({unit_rdata_i[k*32 +: 32], unit_rflags_i[k*NUSFLAGS +: NUSFLAGS]}),
            .i_pop   (w_buf_pop[k]),
            .o_dat   (w_buf_dat[k]),
            .o_empty (w_buf_empty[k]),
            .o_cnt   (w_buf_cnt[k])
        );
    end

    always_comb begin
        w_head_rdy = w_tag_head[SEL_W];
        w_head_dat = '0;
        w_head_sel = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!w_tag_head[SEL_W] && (w_tag_head[SEL_W-1:0] == SEL_W'(k))) begin
                w_head_sel[k] = 1'b1;
                w_head_rdy    = ~w_buf_empty[k];
                w_head_dat    = w_buf_dat[k];
            end
        end
    end

    assign w_pop        = ~w_tag_empty & w_head_rdy;
    assign w_buf_pop    = w_head_sel & {NUM_UNITS{w_pop}};
    assign apu_rvalid_o = w_pop;
    assign apu_rdata_o  = w_pop ? w_head_dat[RW-1:NUSFLAGS] : '0;
    assign apu_rflags_o = w_pop ? w_head_dat[NUSFLAGS-1:0] : '0;

    // r_out counts granted-but-unreturned ops per unit, including buffered ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                r_out[k] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                r_out[k] <= r_out[k] + CW'(w_unit_req[k] & unit_gnt_i[k]) - CW'(w_buf_pop[k]);
            end
            if ((apu_gnt_o & ~w_sel_vld) | (|(unit_rvalid_i & ~w_cap))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o          = (w_cnt != '0);
    assign err_o           = r_err;
    assign unit_operands_o = apu_operands_i;
    assign unit_op_o       = apu_op_i;
    assign unit_flags_o    = apu_flags_i;
endmodule
